// File: rtl/iir1_tdm_filter.sv
`default_nettype none
// ============================================================================
// Module   : iir1_tdm_filter
// Purpose  : Time-multiplexed multi-channel first-order IIR section.
//            Per channel: y[n] = x[n] - x[n-1] - ((a1*y[n-1]) >>> COEF_FRAC),
//            with per-channel coefficient file, optional truncated product
//            (approximate mode) and output saturation to DATA_W bits.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            in_valid/in_ready   - input stream handshake
//            in_ch, x_in         - input channel and signed sample
//            approx_en           - captured with each accepted sample
//            cfg_we/cfg_clr      - write a1 / clear state for cfg_ch
//            cfg_ch, cfg_a1      - config channel and coefficient
//            out_valid/out_ready - output stream handshake
//            out_ch, y_out       - output channel and filtered sample
//            sat_flag            - sticky saturation indicator
// Revision : 1.0 - initial release
// ============================================================================
module iir1_tdm_filter #(
    parameter int DATA_W     = 32,
    parameter int COEF_W     = 11,
    parameter int COEF_FRAC  = 10,
    parameter int CHANNELS   = 4,
    parameter int TRUNC_BITS = 12,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     approx_en,
    input  logic                     cfg_we,
    input  logic                     cfg_clr,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic signed [COEF_W-1:0] cfg_a1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     sat_flag
);

    localparam int PW = DATA_W + COEF_W;   // exact product width
    localparam int SW = PW + 2;            // difference width, no overflow possible

    localparam logic [PW-1:0] PROD_ONE   = PW'(1);
    localparam logic [PW-1:0] TRUNC_MASK = ~((PROD_ONE << TRUNC_BITS) - PROD_ONE);

    localparam logic signed [SW-1:0] Y_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] Y_MIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Per-channel state and coefficient file
    logic signed [DATA_W-1:0] x_prev_q [CHANNELS];
    logic signed [DATA_W-1:0] y_prev_q [CHANNELS];
    logic signed [COEF_W-1:0] a1_q     [CHANNELS];

    // S1 operand stage
    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_x_q;
    logic [CH_W-1:0]          s1_ch_q;
    logic signed [COEF_W-1:0] s1_a1_q;
    logic                     s1_approx_q;

    // OUT result stage
    logic                     out_valid_q;
    logic [CH_W-1:0]          out_ch_q;
    logic signed [DATA_W-1:0] y_out_q;
    logic                     sat_flag_q;

    logic                     en;
    logic signed [COEF_W-1:0] a1_rd;
    logic signed [DATA_W-1:0] x_prev_rd;
    logic signed [DATA_W-1:0] y_prev_rd;
    logic signed [PW-1:0]     a1_ext;
    logic signed [PW-1:0]     y_prev_ext;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_m;
    logic signed [PW-1:0]     fb;
    logic signed [SW-1:0]     sum;
    logic signed [DATA_W-1:0] y_d;
    logic                     sat_d;

    // Whole pipeline advances unless a held output is being backpressured.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Coefficient lookup for the incoming sample. Indices outside the
    // channel range match nothing and read as zero.
    always_comb begin
        a1_rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ch == CH_W'(i)) begin
                a1_rd = a1_q[i];
            end
        end
    end

    // State lookup for the sample in S1. Out-of-range channels see zero
    // state and a zero coefficient, so they pass x straight through.
    always_comb begin
        x_prev_rd = '0;
        y_prev_rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s1_ch_q == CH_W'(i)) begin
                x_prev_rd = x_prev_q[i];
                y_prev_rd = y_prev_q[i];
            end
        end
    end

    // Feedback product, optional truncation, arithmetic scaling
    assign a1_ext     = {{DATA_W{s1_a1_q[COEF_W-1]}}, s1_a1_q};
    assign y_prev_ext = {{COEF_W{y_prev_rd[DATA_W-1]}}, y_prev_rd};
    assign prod       = a1_ext * y_prev_ext;
    assign prod_m     = s1_approx_q ? $signed(prod & TRUNC_MASK) : prod;
    assign fb         = prod_m >>> COEF_FRAC;

    assign sum = {{(SW-DATA_W){s1_x_q[DATA_W-1]}}, s1_x_q}
               - {{(SW-DATA_W){x_prev_rd[DATA_W-1]}}, x_prev_rd}
               - {{(SW-PW){fb[PW-1]}}, fb};

    assign sat_d = (sum > Y_MAX) || (sum < Y_MIN);

    always_comb begin
        y_d = sum[DATA_W-1:0];
        if (sat_d) begin
            y_d = sum[SW-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_ch_q     <= '0;
            s1_a1_q     <= '0;
            s1_approx_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_out_q     <= '0;
            sat_flag_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                x_prev_q[i] <= '0;
                y_prev_q[i] <= '0;
                a1_q[i]     <= '0;
            end
        end else begin
            if (en) begin
                // a1_q is read before any same-edge cfg write lands
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_x_q      <= x_in;
                    s1_ch_q     <= in_ch;
                    s1_a1_q     <= a1_rd;
                    s1_approx_q <= approx_en;
                end

                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_out_q    <= y_d;
                    out_ch_q   <= s1_ch_q;
                    sat_flag_q <= sat_flag_q | sat_d;
                end
            end

            for (int i = 0; i < CHANNELS; i++) begin
                // Write-back coincides with the next sample entering S1,
                // so same-channel back-to-back samples need no forwarding.
                if (en && s1_valid_q && (s1_ch_q == CH_W'(i))) begin
                    x_prev_q[i] <= s1_x_q;
                    y_prev_q[i] <= y_d;
                end
                // Placed after the write-back so a coincident clear wins.
                if (cfg_clr && (cfg_ch == CH_W'(i))) begin
                    x_prev_q[i] <= '0;
                    y_prev_q[i] <= '0;
                end
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    a1_q[i] <= cfg_a1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign y_out     = y_out_q;
    assign sat_flag  = sat_flag_q;

endmodule
`default_nettype wire
